// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage between the EX/MEM latch and a word-only Dmem.
// Loads extract and extend a byte/half from the read word (big-endian lanes).
// Word stores write directly. Sub-word stores take two cycles: the first cycle
// reads the word and merges the new lane, and the second cycle writes it back.
// The MEM/WB latch is registered here.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, a misaligned
// half or word access traps. When it is undefined, the low offset bits are
// silently aligned.
module mem_access_unit #(
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        dmem_ena,
  output logic        dmem_wena,
  output logic [31:0] dmem_addr_in,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_mem,
  output logic [31:0] exc_addr
);

  // state  | meaning
  // IDLE   | normal access; loads, word stores and non-memory ops complete here
  // RMW_WR | write back the merged word of a sub-word store
  typedef enum logic {IDLE, RMW_WR} state_t;

  localparam logic [32:0] BASE33 = {1'b0, DMEM_BASE};
  localparam logic [32:0] END33  = BASE33 + (33'(DMEM_WORDS) << 2);

  state_t      state, state_nxt;
  logic [31:0] rmw_buf, rmw_addr;
  logic [31:0] word_addr;
  logic        live, is_mem, is_sub, in_range, misalign, fault, start_rmw;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data, merged;

  // Classify the instruction in EX/MEM: liveness, range and alignment faults.
  always_comb begin
    word_addr = {ex_addr[31:2], 2'b00};
    live      = ex_valid & ~flush;
    is_mem    = ex_mem_read | ex_mem_write;
    is_sub    = ~ex_size[1];
    in_range  = ({1'b0, ex_addr} >= BASE33) && ({1'b0, ex_addr} < END33);
`ifdef MEM_MISALIGN_TRAP_EN
    misalign  = ((ex_size == 2'b01) & ex_addr[0]) | (ex_size[1] & (|ex_addr[1:0]));
`else
    misalign  = 1'b0;
`endif
    fault     = live & is_mem & (~in_range | misalign);
    start_rmw = (state == IDLE) & live & ex_mem_write & is_sub & ~fault;
  end

  // Lane selection for loads and lane merge for sub-word stores (byte 0 = [31:24]).
  always_comb begin
    lane_byte = dmem_rdata[31:24];
    case (ex_addr[1:0])
      2'd0: lane_byte = dmem_rdata[31:24];
      2'd1: lane_byte = dmem_rdata[23:16];
      2'd2: lane_byte = dmem_rdata[15:8];
      2'd3: lane_byte = dmem_rdata[7:0];
      default: lane_byte = dmem_rdata[31:24];
    endcase
    lane_half = ex_addr[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];

    case (ex_size)
      2'b00:   load_data = ex_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = ex_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = dmem_rdata;
    endcase

    merged = dmem_rdata;
    if (ex_size == 2'b00) begin
      case (ex_addr[1:0])
        2'd0: merged[31:24] = ex_wdata[7:0];
        2'd1: merged[23:16] = ex_wdata[7:0];
        2'd2: merged[15:8]  = ex_wdata[7:0];
        2'd3: merged[7:0]   = ex_wdata[7:0];
        default: merged = dmem_rdata;
      endcase
    end else if (ex_addr[1]) begin
      merged[15:0] = ex_wdata[15:0];
    end else begin
      merged[31:16] = ex_wdata[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and Dmem/stall drive.
  always_comb begin
    state_nxt     = state;
    dmem_ena      = 1'b0;
    dmem_wena     = 1'b0;
    dmem_addr_in  = word_addr;
    dmem_addr_out = word_addr;
    dmem_wdata    = ex_wdata;
    stall         = 1'b0;
    case (state)
      IDLE: begin
        if (live & is_mem & ~fault) begin
          dmem_ena = 1'b1;
          if (ex_mem_write & ~is_sub) dmem_wena = 1'b1;
        end
        if (start_rmw) begin
          stall     = 1'b1;
          state_nxt = RMW_WR;
        end
      end
      RMW_WR: begin
        dmem_addr_in  = rmw_addr;
        dmem_addr_out = rmw_addr;
        dmem_wdata    = rmw_buf;
        state_nxt     = IDLE;
        if (!flush) begin
          dmem_ena  = 1'b1;
          dmem_wena = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the merged word and its address while the sub-word store stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rmw_buf  <= 32'h0;
      rmw_addr <= 32'h0;
    end else if (start_rmw) begin
      rmw_buf  <= merged;
      rmw_addr <= word_addr;
    end
  end

  // MEM/WB latch and exception reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0;
      exc_mem      <= 1'b0;
      exc_addr     <= 32'h0;
    end else if (state == RMW_WR) begin
      wb_valid     <= ~flush;
      wb_reg_write <= 1'b0;
      wb_rd        <= ex_rd;
      wb_data      <= ex_addr;
      exc_mem      <= 1'b0;
    end else begin
      exc_mem <= fault;
      if (fault) exc_addr <= ex_addr;
      wb_rd   <= ex_rd;
      wb_data <= (live & ex_mem_read & ~fault) ? load_data : ex_addr;
      if (!live || fault || start_rmw) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end else begin
        wb_valid     <= 1'b1;
        wb_reg_write <= ex_reg_write;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// A byte-addressed big-endian reference memory predicts the load results and the
// Dmem writes. A word-array Dmem model serves the DUT. Expected results are queued
// at issue time, and a negedge monitor pops them and compares.
module tb_mem_access_unit;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          WORDS = 1024;
  localparam int          BYTES = 4 * WORDS;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        e;
    logic [31:0] ea;
  } wb_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic        ex_unsigned = 1'b0, ex_reg_write = 1'b0, flush = 1'b0;
  logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0;
  logic [4:0]  ex_rd = 5'd0;
  logic        dmem_ena, dmem_wena, stall, wb_valid, wb_reg_write, exc_mem;
  logic [31:0] dmem_addr_in, dmem_addr_out, dmem_wdata, dmem_rdata, wb_data, exc_addr;
  logic [4:0]  wb_rd;

  int   checks = 0;
  int   errors = 0;
  logic exp_stall = 1'b0, exp_ena = 1'b0, exp_reset = 1'b1, end_chk = 1'b0;
  logic [31:0] last_exc = 32'h0;
  wb_t  wbq[$];
  wr_t  wrq[$];
  wb_t  mr;
  wr_t  mw;

  logic [31:0] dm [WORDS];
  bit          dm_init = 1'b0;
  logic [7:0]  ref_b [BYTES];

  always #5 clk = ~clk;

  mem_access_unit #(.DMEM_BASE(BASE), .DMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .flush(flush), .dmem_ena(dmem_ena), .dmem_wena(dmem_wena),
    .dmem_addr_in(dmem_addr_in), .dmem_addr_out(dmem_addr_out), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .stall(stall), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_mem(exc_mem), .exc_addr(exc_addr)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit in_dm(logic [31:0] a);
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(BYTES)));
  endfunction

  function automatic logic [31:0] dm_read(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (in_dm(a)) return dm[off[11:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign dmem_rdata = dm_read(dmem_addr_out);

  // Dmem model: filled with a fixed pattern on the first edge, then written by the DUT.
  always @(posedge clk) begin
    if (!dm_init) begin
      for (int i = 0; i < WORDS; i++) dm[i] <= init_word(i);
      dm_init <= 1'b1;
    end else if (dmem_ena && dmem_wena && in_dm(dmem_addr_in)) begin
      dm[10'((dmem_addr_in - BASE) >> 2)] <= dmem_wdata;
    end
  end

  function automatic bit mis(logic [1:0] sz, logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_word(int o);
    return {ref_b[o], ref_b[o+1], ref_b[o+2], ref_b[o+3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: per-cycle stall/enable checks, Dmem write scoreboard, and MEM/WB scoreboard.
  always @(negedge clk) begin
    if (exp_reset) begin
      chk("rst_wb_valid", 32'(wb_valid), 32'h0);
      chk("rst_wb_reg_write", 32'(wb_reg_write), 32'h0);
      chk("rst_wb_rd", 32'(wb_rd), 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_exc_mem", 32'(exc_mem), 32'h0);
      chk("rst_exc_addr", exc_addr, 32'h0);
      chk("rst_dmem_wena", 32'(dmem_wena), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
    end else if (rst) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("dmem_ena", 32'(dmem_ena), 32'(exp_ena));
      if (dmem_ena && dmem_wena) begin
        if (wrq.size() == 0) chk("unexpected_write", 32'h1, 32'h0);
        else begin
          mw = wrq.pop_front();
          chk("wr_addr", dmem_addr_in, mw.a);
          chk("wr_data", dmem_wdata, mw.d);
        end
      end
      if (wb_valid || exc_mem) begin
        if (wbq.size() == 0) chk("unexpected_wb", 32'h1, 32'h0);
        else begin
          mr = wbq.pop_front();
          chk("wb_valid", 32'(wb_valid), 32'(mr.v));
          chk("exc_mem", 32'(exc_mem), 32'(mr.e));
          chk("exc_addr", exc_addr, mr.ea);
          if (mr.v) begin
            chk("wb_reg_write", 32'(wb_reg_write), 32'(mr.rw));
            chk("wb_rd", 32'(wb_rd), 32'(mr.rd));
            chk("wb_data", wb_data, mr.d);
          end
        end
      end
    end
    if (end_chk) begin
      chk("wb_queue_drained", 32'(wbq.size()), 32'h0);
      chk("wr_queue_drained", 32'(wrq.size()), 32'h0);
    end
  end

  // rmw_mode: 0 normal, 1 flush during write-back, 2 reset during write-back.
  task automatic issue(input logic rd_, input logic wr_, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       input logic regw, input logic [4:0] rdn, input logic vld,
                       input logic fl, input int rmw_mode,
                       input bit use_lit, input logic [31:0] lit);
    logic live, is_mem, flt, sub;
    logic [31:0] eff, data, o32;
    logic [7:0]  b0;
    logic [15:0] h0;
    int o;
    wb_t r;
    wr_t w;
    @(posedge clk); #1;
    ex_valid = vld; ex_mem_read = rd_; ex_mem_write = wr_; ex_size = sz;
    ex_unsigned = uns; ex_addr = a; ex_wdata = wd; ex_reg_write = regw;
    ex_rd = rdn; flush = fl;
    live   = vld && !fl;
    is_mem = rd_ || wr_;
    flt    = live && is_mem && (!in_dm(a) || mis(sz, a));
    sub    = wr_ && (sz < 2'd2);
    eff    = (sz == 2'd0) ? a : (sz == 2'd1) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
    o32    = eff - BASE;
    o      = int'(o32);
    exp_ena   = live && is_mem && !flt;
    exp_stall = live && sub && !flt;
    if (flt) begin
      last_exc = a;
      r = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, a};
      wbq.push_back(r);
    end else if (live) begin
      data = a;
      if (rd_) begin
        b0 = ref_b[o];
        h0 = {ref_b[o], ref_b[o+1]};
        case (sz)
          2'd0:    data = uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
          2'd1:    data = uns ? {16'h0, h0} : {{16{h0[15]}}, h0};
          default: data = ref_word(o);
        endcase
        if (use_lit) data = lit;
      end
      if (wr_ && !(sub && rmw_mode != 0)) begin
        case (sz)
          2'd0: ref_b[o] = wd[7:0];
          2'd1: begin ref_b[o] = wd[15:8]; ref_b[o+1] = wd[7:0]; end
          default: begin
            ref_b[o] = wd[31:24]; ref_b[o+1] = wd[23:16];
            ref_b[o+2] = wd[15:8]; ref_b[o+3] = wd[7:0];
          end
        endcase
        w.a = {eff[31:2], 2'b00};
        w.d = ref_word(o & ~3);
        wrq.push_back(w);
      end
      if (!sub) begin
        r = '{1'b1, regw, rdn, data, 1'b0, last_exc};
        wbq.push_back(r);
      end
    end
    if (exp_stall) begin
      @(posedge clk); #1;
      exp_stall = 1'b0;
      if (rmw_mode == 1) begin
        flush = 1'b1; exp_ena = 1'b0;
      end else if (rmw_mode == 2) begin
        rst = 1'b0; ex_valid = 1'b0; exp_ena = 1'b0; exp_reset = 1'b1; last_exc = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1; exp_reset = 1'b0;
      end else begin
        exp_ena = 1'b1;
        r = '{1'b1, 1'b0, rdn, a, 1'b0, last_exc};
        wbq.push_back(r);
      end
    end
  endtask

  task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [4:0] rdn, input bit use_lit, input logic [31:0] lit);
    issue(1'b1, 1'b0, sz, uns, a, 32'h0, 1'b1, rdn, 1'b1, 1'b0, 0, use_lit, lit);
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int mode);
    issue(1'b0, 1'b1, sz, 1'b0, a, wd, 1'b0, 5'd0, 1'b1, 1'b0, mode, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, wd;
    int k, r;
    for (int i = 0; i < WORDS; i++) begin
      wd = init_word(i);
      ref_b[4*i] = wd[31:24]; ref_b[4*i+1] = wd[23:16];
      ref_b[4*i+2] = wd[15:8]; ref_b[4*i+3] = wd[7:0];
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; exp_reset = 1'b0;

    do_store(2'd2, 32'h1001_0008, 32'h1122_3344, 0);
    do_load(2'd2, 1'b0, 32'h1001_0008, 5'd3, 1'b1, 32'h1122_3344);
    do_store(2'd0, 32'h1001_0009, 32'h0000_00AB, 0);
    do_load(2'd2, 1'b0, 32'h1001_0008, 5'd4, 1'b1, 32'h11AB_3344);
    do_load(2'd0, 1'b0, 32'h1001_0009, 5'd5, 1'b1, 32'hFFFF_FFAB);
    do_load(2'd0, 1'b1, 32'h1001_0009, 5'd6, 1'b1, 32'h0000_00AB);
    do_load(2'd1, 1'b0, 32'h1001_000A, 5'd7, 1'b1, 32'h0000_3344);
    do_load(2'd2, 1'b0, 32'h1001_1000, 5'd8, 1'b0, 32'h0);
    do_load(2'd2, 1'b0, 32'h1001_0FFC, 5'd9, 1'b0, 32'h0);
    do_load(2'd2, 1'b0, 32'h1000_FFFC, 5'd10, 1'b0, 32'h0);
    do_load(2'd1, 1'b0, 32'h1001_0001, 5'd11, 1'b0, 32'h0);
    do_store(2'd1, 32'h1001_0FFE, 32'h0000_BEEF, 0);
    do_load(2'd1, 1'b1, 32'h1001_0FFE, 5'd12, 1'b1, 32'h0000_BEEF);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, 1'b1, 5'd13, 1'b1, 1'b1, 0, 1'b0, 32'h0);
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 5'd14, 1'b1, 1'b0, 0, 1'b0, 32'h0);
    do_store(2'd0, 32'h1001_0008, 32'h0000_0077, 1);
    do_load(2'd2, 1'b0, 32'h1001_0008, 5'd15, 1'b1, 32'h11AB_3344);
    do_store(2'd0, 32'h1001_000B, 32'h0000_0055, 2);
    do_load(2'd2, 1'b0, 32'h1001_0008, 5'd16, 1'b1, 32'h11AB_3344);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 32'($urandom_range(0, 63));
      else if (r == 7) a = BASE + 32'd4088 + 32'($urandom_range(0, 15));
      else if (r == 8) a = BASE - 32'($urandom_range(1, 8));
      else             a = $urandom;
      k = $urandom_range(0, 9);
      issue(k < 4, (k >= 4) && (k < 7), 2'($urandom_range(0, 3)), 1'($urandom),
            a, $urandom, 1'($urandom), 5'($urandom), k != 8, k == 9,
            ($urandom_range(0, 15) == 0) ? 1 : 0, 1'b0, 32'h0);
    end

    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0; exp_ena = 1'b0; exp_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 end_chk = 1'b1;
    @(posedge clk);
    #1 end_chk = 1'b0;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
